// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//
// Sequencer for CPU PUSH/POP instructions. It is the only writer of the stack
// pointer kept in the register file: it reads the live SP on sp_in, performs
// the single data-memory access a command needs, and writes the updated SP
// back through the register-file write port. The CPU stalls while cmd_ready
// is low.
//
// The stack is empty-descending:
//   - SP points at the next free byte.
//   - A push writes mem[SP] and then decrements SP.
//   - A pop increments SP and then reads mem[SP].
//
// Ports
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   cmd_valid        command request, accepted only while cmd_ready is high
//   cmd_pop          0 = PUSH, 1 = POP (sampled with cmd_valid)
//   cmd_data         push data (sampled with cmd_valid)
//   cmd_ready        high only while idle
//   done             one-cycle completion pulse
//   pop_data         last successfully popped byte, held between pops
//   err_ovf          push refused because the stack is full (with done)
//   err_unf          pop refused because the stack is empty (with done)
//   sp_in            current SP from the register file
//   rf_wr_en         register-file write enable for the new SP
//   rf_wr_addr       register-file write address (always SP_ADDR)
//   rf_wr_data       new SP value
//   dmem_addr        data-memory address
//   dmem_wr          data-memory write strobe
//   dmem_wdata       data-memory write data
//   dmem_rd          data-memory read strobe; data returns next cycle
//   dmem_rdata       data-memory read data
// -----------------------------------------------------------------------------
module stack_ctrl #(
    parameter logic [3:0] SP_ADDR     = 4'd15,
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_pop,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       done,
    output logic [7:0] pop_data,
    output logic       err_ovf,
    output logic       err_unf,
    input  logic [7:0] sp_in,
    output logic       rf_wr_en,
    output logic [3:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic [7:0] dmem_addr,
    output logic       dmem_wr,
    output logic       dmem_rd,
    output logic [7:0] dmem_wdata,
    input  logic [7:0] dmem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_WR = 3'd1,
        ST_POP_RD  = 3'd2,
        ST_POP_CAP = 3'd3,
        ST_SP_WB   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0] r_data;      // push data latched at accept
    logic [7:0] r_sp_q;      // SP snapshot taken at accept
    logic [7:0] r_sp_new;    // SP value to write back
    logic       r_err_ovf;
    logic       r_err_unf;
    logic [7:0] r_pop_data;

    // Refusal decisions are made on the live sp_in in the accept cycle,
    // which is exactly the value latched into r_sp_q.
    logic w_ovf;
    logic w_unf;
    logic w_accept;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_ovf    = !cmd_pop && (sp_in < STACK_LIMIT);
    assign w_unf    =  cmd_pop && (sp_in >= STACK_TOP);

    // SP is the only register this block ever writes.
    assign rf_wr_addr = SP_ADDR;
    assign pop_data   = r_pop_data;

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_data     <= 8'h00;
            r_sp_q     <= 8'h00;
            r_sp_new   <= 8'h00;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_pop_data <= 8'h00;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_data    <= cmd_data;
                r_sp_q    <= sp_in;
                // Cleared on every accept so a stale flag never reaches DONE.
                r_err_ovf <= w_ovf;
                r_err_unf <= w_unf;
            end

            // The 8-bit arithmetic wraps on purpose: with STACK_LIMIT = 0 a
            // push at SP = 8'h00 yields 8'hFF.
            if (r_state == ST_PUSH_WR) begin
                r_sp_new <= r_sp_q - 8'd1;
            end
            if (r_state == ST_POP_RD) begin
                r_sp_new <= r_sp_q + 8'd1;
            end

            // Read data arrives one cycle after the dmem_rd strobe.
            if (r_state == ST_POP_CAP) begin
                r_pop_data <= dmem_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode. Each strobe is tied to exactly one state,
    // so dmem_wr, dmem_rd and rf_wr_en can never overlap and each lasts a
    // single cycle per command.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        err_ovf      = 1'b0;
        err_unf      = 1'b0;
        rf_wr_en     = 1'b0;
        rf_wr_data   = 8'h00;
        dmem_addr    = 8'h00;
        dmem_wr      = 1'b0;
        dmem_rd      = 1'b0;
        dmem_wdata   = 8'h00;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_ovf || w_unf) begin
                        w_state_next = ST_DONE;
                    end else if (cmd_pop) begin
                        w_state_next = ST_POP_RD;
                    end else begin
                        w_state_next = ST_PUSH_WR;
                    end
                end
            end

            ST_PUSH_WR: begin
                dmem_wr      = 1'b1;
                dmem_addr    = r_sp_q;
                dmem_wdata   = r_data;
                w_state_next = ST_SP_WB;
            end

            ST_POP_RD: begin
                dmem_rd      = 1'b1;
                dmem_addr    = r_sp_q + 8'd1;
                w_state_next = ST_POP_CAP;
            end

            ST_POP_CAP: begin
                w_state_next = ST_SP_WB;
            end

            ST_SP_WB: begin
                rf_wr_en     = 1'b1;
                rf_wr_data   = r_sp_new;
                w_state_next = ST_DONE;
            end

            ST_DONE: begin
                done         = 1'b1;
                err_ovf      = r_err_ovf;
                err_unf      = r_err_unf;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_pop;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       done;
    logic [7:0] pop_data;
    logic       err_ovf;
    logic       err_unf;
    logic [7:0] sp_in;
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic [7:0] dmem_addr;
    logic       dmem_wr;
    logic       dmem_rd;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    stack_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_pop    (cmd_pop),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .pop_data   (pop_data),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .sp_in      (sp_in),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .dmem_addr  (dmem_addr),
        .dmem_wr    (dmem_wr),
        .dmem_rd    (dmem_rd),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file SP and data-memory models
    logic [7:0] mem [0:255];
    logic [7:0] rf_sp;
    logic       sp_load_en;
    logic [7:0] sp_load_val;

    assign sp_in = rf_sp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rf_sp      = 8'h00;
        dmem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (dmem_wr) mem[dmem_addr] <= dmem_wdata;
        if (dmem_rd) dmem_rdata <= mem[dmem_addr];
        if (sp_load_en) rf_sp <= sp_load_val;
        else if (rf_wr_en && rf_wr_addr == 4'd15) rf_sp <= rf_wr_data;
    end

    // Per-command observations gathered by watch()
    int         m_lat;
    int         m_wr_cnt, m_rd_cnt, m_rf_cnt, m_overlap, m_ready_busy;
    logic [7:0] m_wr_addr, m_wr_data, m_rd_addr, m_rf_data;
    logic [3:0] m_rf_addr;
    logic       m_ovf, m_unf;

    task automatic set_sp(input logic [7:0] v);
        @(negedge clk);
        sp_load_en  = 1'b1;
        sp_load_val = v;
        @(posedge clk);
        #1 sp_load_en = 1'b0;
    endtask

    task automatic issue(input logic pop, input logic [7:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_pop   = pop;
        cmd_data  = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Observes cycles after the accept edge until done (bounded). With toggle
    // set, cmd_valid is flipped every busy cycle with a different command.
    task automatic watch(input logic toggle);
        m_lat = 0; m_wr_cnt = 0; m_rd_cnt = 0; m_rf_cnt = 0;
        m_overlap = 0; m_ready_busy = 0;
        m_wr_addr = 0; m_wr_data = 0; m_rd_addr = 0; m_rf_data = 0; m_rf_addr = 0;
        m_ovf = 0; m_unf = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (cmd_ready) m_ready_busy++;
            if (int'(dmem_wr) + int'(dmem_rd) + int'(rf_wr_en) > 1) m_overlap++;
            if (dmem_wr) begin m_wr_cnt++; m_wr_addr = dmem_addr; m_wr_data = dmem_wdata; end
            if (dmem_rd) begin m_rd_cnt++; m_rd_addr = dmem_addr; end
            if (rf_wr_en) begin m_rf_cnt++; m_rf_addr = rf_wr_addr; m_rf_data = rf_wr_data; end
            if (done) begin
                m_lat = k; m_ovf = err_ovf; m_unf = err_unf;
                break;
            end
            if (toggle) begin
                cmd_valid = ~cmd_valid;
                cmd_pop   = 1'b1;
                cmd_data  = 8'h22;
            end
        end
        $display("txn: lat=%0d wr=%0d@%h/%h rd=%0d@%h rf=%0d<=%h ovf=%b unf=%b pop_data=%h sp=%h",
                 m_lat, m_wr_cnt, m_wr_addr, m_wr_data, m_rd_cnt, m_rd_addr,
                 m_rf_cnt, m_rf_data, m_ovf, m_unf, pop_data, rf_sp);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_pop = 1'b0; cmd_data = 8'h00;
        sp_load_en = 1'b0; sp_load_val = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if ({done, err_ovf, err_unf, rf_wr_en, dmem_wr, dmem_rd} !== 6'b0) begin errors++;
            $display("FAIL reset_strobes: got %b expected 000000", {done, err_ovf, err_unf, rf_wr_en, dmem_wr, dmem_rd}); end
        checks++; if ({pop_data, rf_wr_data, dmem_addr, dmem_wdata} !== 32'h0) begin errors++;
            $display("FAIL reset_data: got %h expected 00000000", {pop_data, rf_wr_data, dmem_addr, dmem_wdata}); end
        rst = 1'b0;
        $display("txn: reset released");
    endtask

    task automatic test_reset_mid_pop();
        int done_seen;
        set_sp(8'hFE);
        issue(1'b1, 8'h00);
        @(negedge clk);  // POP_RD
        checks++; if (dmem_rd !== 1'b1 || dmem_addr !== 8'hFF) begin errors++;
            $display("FAIL midpop_rd: got rd=%b addr=%h expected rd=1 addr=ff", dmem_rd, dmem_addr); end
        @(negedge clk);  // POP_CAP
        rst = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midpop_ready: got %b expected 1", cmd_ready); end
        checks++; if ({done, err_ovf, err_unf, rf_wr_en, dmem_wr, dmem_rd} !== 6'b0) begin errors++;
            $display("FAIL midpop_strobes: got %b expected 000000", {done, err_ovf, err_unf, rf_wr_en, dmem_wr, dmem_rd}); end
        checks++; if ({pop_data, rf_wr_data, dmem_addr, dmem_wdata} !== 32'h0) begin errors++;
            $display("FAIL midpop_data: got %h expected 00000000", {pop_data, rf_wr_data, dmem_addr, dmem_wdata}); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || rf_wr_en) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midpop_no_done: got %0d expected 0", done_seen); end
        checks++; if (rf_sp !== 8'hFE || pop_data !== 8'h00) begin errors++;
            $display("FAIL midpop_state: got sp=%h pop=%h expected sp=fe pop=00", rf_sp, pop_data); end
        $display("txn: reset during POP_CAP");
    endtask

    task automatic test_push();
        set_sp(8'hFF);
        issue(1'b0, 8'hA5);
        watch(1'b0);
        checks++; if (m_lat !== 3) begin errors++; $display("FAIL push_latency: got %0d expected 3", m_lat); end
        checks++; if (m_wr_cnt !== 1 || m_wr_addr !== 8'hFF || m_wr_data !== 8'hA5) begin errors++;
            $display("FAIL push_write: got n=%0d addr=%h data=%h expected n=1 addr=ff data=a5", m_wr_cnt, m_wr_addr, m_wr_data); end
        checks++; if (m_rf_cnt !== 1 || m_rf_addr !== 4'd15 || m_rf_data !== 8'hFE) begin errors++;
            $display("FAIL push_rf: got n=%0d addr=%0d data=%h expected n=1 addr=15 data=fe", m_rf_cnt, m_rf_addr, m_rf_data); end
        checks++; if (m_ovf !== 1'b0 || m_unf !== 1'b0 || m_rd_cnt !== 0 || m_overlap !== 0) begin errors++;
            $display("FAIL push_flags: got ovf=%b unf=%b rd=%0d ovl=%0d expected 0 0 0 0", m_ovf, m_unf, m_rd_cnt, m_overlap); end
        checks++; if (mem[8'hFF] !== 8'hA5 || rf_sp !== 8'hFE) begin errors++;
            $display("FAIL push_result: got mem=%h sp=%h expected mem=a5 sp=fe", mem[8'hFF], rf_sp); end
    endtask

    task automatic test_pop();
        set_sp(8'hFE);
        issue(1'b1, 8'h00);
        watch(1'b0);
        checks++; if (m_lat !== 4) begin errors++; $display("FAIL pop_latency: got %0d expected 4", m_lat); end
        checks++; if (m_rd_cnt !== 1 || m_rd_addr !== 8'hFF || m_wr_cnt !== 0) begin errors++;
            $display("FAIL pop_read: got rd=%0d addr=%h wr=%0d expected rd=1 addr=ff wr=0", m_rd_cnt, m_rd_addr, m_wr_cnt); end
        checks++; if (pop_data !== 8'hA5) begin errors++; $display("FAIL pop_data: got %h expected a5", pop_data); end
        checks++; if (m_rf_cnt !== 1 || m_rf_data !== 8'hFF || rf_sp !== 8'hFF) begin errors++;
            $display("FAIL pop_rf: got n=%0d data=%h sp=%h expected n=1 data=ff sp=ff", m_rf_cnt, m_rf_data, rf_sp); end
        checks++; if (m_ovf !== 1'b0 || m_unf !== 1'b0 || m_overlap !== 0) begin errors++;
            $display("FAIL pop_flags: got ovf=%b unf=%b ovl=%0d expected 0 0 0", m_ovf, m_unf, m_overlap); end
    endtask

    task automatic test_underflow();
        set_sp(8'hFF);
        issue(1'b1, 8'h00);
        watch(1'b0);
        checks++; if (m_lat !== 1) begin errors++; $display("FAIL unf_latency: got %0d expected 1", m_lat); end
        checks++; if (m_unf !== 1'b1 || m_ovf !== 1'b0) begin errors++;
            $display("FAIL unf_flags: got unf=%b ovf=%b expected unf=1 ovf=0", m_unf, m_ovf); end
        checks++; if (m_wr_cnt + m_rd_cnt + m_rf_cnt !== 0) begin errors++;
            $display("FAIL unf_strobes: got %0d expected 0", m_wr_cnt + m_rd_cnt + m_rf_cnt); end
        checks++; if (pop_data !== 8'hA5 || rf_sp !== 8'hFF) begin errors++;
            $display("FAIL unf_state: got pop=%h sp=%h expected pop=a5 sp=ff", pop_data, rf_sp); end
        @(negedge clk);
        checks++; if (err_unf !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL unf_pulse: got unf=%b done=%b expected 0 0", err_unf, done); end
    endtask

    task automatic test_push_boundary();
        set_sp(8'h80);
        issue(1'b0, 8'h3C);
        watch(1'b0);
        checks++; if (m_lat !== 3 || m_ovf !== 1'b0) begin errors++;
            $display("FAIL bnd_ok: got lat=%0d ovf=%b expected lat=3 ovf=0", m_lat, m_ovf); end
        checks++; if (m_wr_addr !== 8'h80 || mem[8'h80] !== 8'h3C || rf_sp !== 8'h7F) begin errors++;
            $display("FAIL bnd_ok_result: got addr=%h mem=%h sp=%h expected 80 3c 7f", m_wr_addr, mem[8'h80], rf_sp); end
        issue(1'b0, 8'h55);
        watch(1'b0);
        checks++; if (m_lat !== 1 || m_ovf !== 1'b1 || m_unf !== 1'b0) begin errors++;
            $display("FAIL bnd_ovf: got lat=%0d ovf=%b unf=%b expected 1 1 0", m_lat, m_ovf, m_unf); end
        checks++; if (m_wr_cnt !== 0 || m_rf_cnt !== 0 || mem[8'h7F] !== 8'h00 || rf_sp !== 8'h7F) begin errors++;
            $display("FAIL bnd_ovf_result: got wr=%0d rf=%0d mem=%h sp=%h expected 0 0 00 7f", m_wr_cnt, m_rf_cnt, mem[8'h7F], rf_sp); end
    endtask

    task automatic test_back_to_back();
        set_sp(8'hFF);
        issue(1'b0, 8'h11);
        watch(1'b1);
        // Hold the next request (a POP) from the done cycle onwards.
        cmd_valid = 1'b1;
        cmd_pop   = 1'b1;
        cmd_data  = 8'h22;
        checks++; if (m_lat !== 3 || m_wr_cnt !== 1 || m_ready_busy !== 0) begin errors++;
            $display("FAIL b2b_push: got lat=%0d wr=%0d ready_busy=%0d expected 3 1 0", m_lat, m_wr_cnt, m_ready_busy); end
        checks++; if (m_rf_data !== 8'hFE || m_wr_data !== 8'h11) begin errors++;
            $display("FAIL b2b_push_data: got rf=%h wd=%h expected fe 11", m_rf_data, m_wr_data); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready); end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        watch(1'b0);
        checks++; if (m_lat !== 4 || m_rd_addr !== 8'hFF || pop_data !== 8'h11) begin errors++;
            $display("FAIL b2b_pop: got lat=%0d addr=%h data=%h expected 4 ff 11", m_lat, m_rd_addr, pop_data); end
        checks++; if (rf_sp !== 8'hFF || m_unf !== 1'b0) begin errors++;
            $display("FAIL b2b_pop_sp: got sp=%h unf=%b expected ff 0", rf_sp, m_unf); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_pop();
        test_push();
        test_pop();
        test_underflow();
        test_push_boundary();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
